// File: rtl/modmul_barrett_pkg.sv
// Shared NTT butterfly parameters and the Barrett constant helper.
package modmul_barrett_pkg;

    localparam int NTT_WIDTH     = 14;
    localparam int NTT_MODULUS   = 12289;
    localparam int NTT_TAG_WIDTH = 8;

    // floor(2^(2*width) / q); fits in width+1 bits whenever 2^(width-1) < q
    function automatic longint unsigned barrett_mu(input int width, input int q);
        return (64'd1 << (2 * width)) / 64'(q);
    endfunction

endpackage

// File: rtl/modmul_barrett_if.sv
// Operand/result handshake bundle for the Barrett multiplier.
interface modmul_barrett_if #(
    parameter int WIDTH     = 14,
    parameter int TAG_WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic [TAG_WIDTH-1:0] in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_c;
    logic [TAG_WIDTH-1:0] out_tag;
    logic                 range_err;

    modport master (
        output in_valid, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_c, out_tag, range_err
    );

    modport slave (
        input  in_valid, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_c, out_tag, range_err
    );
endinterface

// File: rtl/modmul_barrett_stage.sv
// One pipeline register: valid bit plus payload; payload only loads on a valid
// beat so downstream data holds across bubbles.
module modmul_barrett_stage #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic          i_valid,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    output logic [DW-1:0] o_data
);

    logic          r_valid;
    logic [DW-1:0] r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_en) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/modmul_barrett.sv
// Four-stage Barrett modular multiplier (a*b mod q) with tag sideband and
// global stall; feeds the butterfly modadd/modsub units.
module modmul_barrett
    import modmul_barrett_pkg::*;
#(
    parameter int WIDTH     = NTT_WIDTH,
    parameter int MODULUS   = NTT_MODULUS,
    parameter int TAG_WIDTH = NTT_TAG_WIDTH
) (
    input logic              clk,
    input logic              rst,
    modmul_barrett_if.slave  bus
);

    localparam int PW = 2 * WIDTH;
    localparam int MW = 3 * WIDTH + 1;
    localparam int RW = WIDTH + 2;
    localparam int TW = TAG_WIDTH;

    localparam logic [WIDTH:0]   MU  = (WIDTH+1)'(barrett_mu(WIDTH, MODULUS));
    localparam logic [WIDTH-1:0] Q_W = WIDTH'(MODULUS);
    localparam logic [RW-1:0]    Q_R = RW'(MODULUS);
    localparam logic [PW-1:0]    Q_P = PW'(MODULUS);

    logic                 w_en;
    logic                 w_s1_v, w_s2_v, w_s3_v, w_s4_v;
    logic [TW+PW-1:0]     w_s1_din, w_s1_d;
    logic [TW+PW+MW-1:0]  w_s2_din, w_s2_d;
    logic [TW+RW-1:0]     w_s3_din, w_s3_d;
    logic [TW+WIDTH-1:0]  w_s4_din, w_s4_d;
    logic [TW-1:0]        w_s1_tag, w_s2_tag, w_s3_tag;
    logic [PW-1:0]        w_s1_p, w_s2_p;
    logic [MW-1:0]        w_s2_m;
    logic [WIDTH:0]       w_s2_t;
    logic [RW-1:0]        w_s3_r, w_r1, w_r2;
    logic                 r_range_err;

    // Whole pipe advances together; no bubble collapsing.
    assign w_en         = bus.out_ready | ~w_s4_v;
    assign bus.in_ready = w_en;

    assign w_s1_din = {bus.in_tag, PW'(bus.in_a) * PW'(bus.in_b)};
    assign {w_s1_tag, w_s1_p} = w_s1_d;

    assign w_s2_din = {w_s1_tag, w_s1_p, MW'(w_s1_p) * MW'(MU)};
    assign {w_s2_tag, w_s2_p, w_s2_m} = w_s2_d;

    // True remainder is < 3q, so only the low RW bits of p - t*q matter.
    assign w_s2_t   = (WIDTH+1)'(w_s2_m >> PW);
    assign w_s3_din = {w_s2_tag, RW'(w_s2_p - PW'(w_s2_t) * Q_P)};
    assign {w_s3_tag, w_s3_r} = w_s3_d;

    assign w_r1     = (w_s3_r >= Q_R) ? w_s3_r - Q_R : w_s3_r;
    assign w_r2     = (w_r1 >= Q_R) ? w_r1 - Q_R : w_r1;
    assign w_s4_din = {w_s3_tag, WIDTH'(w_r2)};

    modmul_barrett_stage #(.DW(TW+PW)) u_s1 (
        .clk(clk), .rst(rst), .i_en(w_en),
        .i_valid(bus.in_valid), .i_data(w_s1_din),
        .o_valid(w_s1_v), .o_data(w_s1_d)
    );

    modmul_barrett_stage #(.DW(TW+PW+MW)) u_s2 (
        .clk(clk), .rst(rst), .i_en(w_en),
        .i_valid(w_s1_v), .i_data(w_s2_din),
        .o_valid(w_s2_v), .o_data(w_s2_d)
    );

    modmul_barrett_stage #(.DW(TW+RW)) u_s3 (
        .clk(clk), .rst(rst), .i_en(w_en),
        .i_valid(w_s2_v), .i_data(w_s3_din),
        .o_valid(w_s3_v), .o_data(w_s3_d)
    );

    modmul_barrett_stage #(.DW(TW+WIDTH)) u_s4 (
        .clk(clk), .rst(rst), .i_en(w_en),
        .i_valid(w_s3_v), .i_data(w_s4_din),
        .o_valid(w_s4_v), .o_data(w_s4_d)
    );

    assign bus.out_valid = w_s4_v;
    assign {bus.out_tag, bus.out_c} = w_s4_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_range_err <= 1'b0;
        end else if (bus.in_valid && w_en && ((bus.in_a >= Q_W) || (bus.in_b >= Q_W))) begin
            r_range_err <= 1'b1;
        end
    end

    assign bus.range_err = r_range_err;

endmodule

// File: tb/tb_modmul_barrett.sv
// Directed bench for modmul_barrett: corners, latency, bubbles, streaming,
// backpressure, range flag and mid-stream reset.
module tb_modmul_barrett;

    localparam int W   = 14;
    localparam int Q   = 12289;
    localparam int TGW = 8;

    logic clk;
    logic rst;

    modmul_barrett_if #(.WIDTH(W), .TAG_WIDTH(TGW)) bus ();

    modmul_barrett #(.WIDTH(W), .MODULUS(Q), .TAG_WIDTH(TGW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_total;
    int n_pass;
    int n_acc;
    int n_out;
    logic [W+TGW-1:0] exp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no completion, required finish before time limit");
        $fatal(1, "simulation timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] ref_mul(input int a, input int b);
        longint unsigned prod;
        prod = longint'(a) * longint'(b);
        return W'(prod % Q);
    endfunction

    // Scoreboard for one cycle: check any output transfer, record any input
    // transfer, then advance the clock.
    task automatic sb_cycle();
        logic [W+TGW-1:0] e;
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_output", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("stream_tag_result", {10'd0, bus.out_tag, bus.out_c}, {10'd0, e});
                n_out++;
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back({bus.in_tag, ref_mul(int'(bus.in_a), int'(bus.in_b))});
            n_acc++;
        end
        step();
    endtask

    task automatic corner(input int a, input int b, input logic [7:0] tag, input int expc);
        bus.in_a     = W'(a);
        bus.in_b     = W'(b);
        bus.in_tag   = tag;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        chk("corner_not_early", {31'd0, bus.out_valid}, 32'd0);
        step();
        chk("corner_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("corner_c", {18'd0, bus.out_c}, expc);
        chk("corner_tag", {24'd0, bus.out_tag}, {24'd0, tag});
    endtask

    initial begin
        bit [3:0] pat;
        int cyc;
        n_total = 0;
        n_pass = 0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("reset_range_err", {31'd0, bus.range_err}, 32'd0);
        chk("reset_out_c", {18'd0, bus.out_c}, 32'd0);
        chk("reset_out_tag", {24'd0, bus.out_tag}, 32'd0);
        chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);

        corner(12288, 12288, 8'hA1, 1);
        corner(0, 5000, 8'hA2, 0);
        corner(1, 12288, 8'hA3, 12288);
        corner(2, 6145, 8'hA4, 1);

        // Bubble pattern 1,0,0,1 with (3,4)->12 and (5,6)->30
        pat = 4'b1001;
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = (i < 4) ? pat[i] : 1'b0;
            bus.in_a     = (i == 3) ? W'(5) : W'(3);
            bus.in_b     = (i == 3) ? W'(6) : W'(4);
            bus.in_tag   = (i == 3) ? 8'h11 : 8'h10;
            step();
            if (i >= 3) chk("bubble_valid", {31'd0, bus.out_valid}, (i < 7) ? {31'd0, pat[i-3]} : 32'd0);
            if (i == 3 || i == 4 || i == 5) chk("bubble_hold_c", {18'd0, bus.out_c}, 32'd12);
            if (i == 6 || i == 7) chk("bubble_second_c", {18'd0, bus.out_c}, 32'd30);
            if (i == 6) chk("bubble_second_tag", {24'd0, bus.out_tag}, 32'h11);
        end

        // Back-to-back stream with out_ready held high
        n_acc = 0;
        n_out = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = W'($urandom_range(0, Q - 1));
            bus.in_b     = W'($urandom_range(0, Q - 1));
            bus.in_tag   = 8'(i);
            sb_cycle();
        end
        chk("tp_accepted", n_acc, 32'd1000);
        chk("tp_one_per_cycle", n_out, 32'd996);
        bus.in_valid = 1'b0;
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) sb_cycle();
        chk("tp_drained", exp_q.size(), 32'd0);
        chk("tp_count", n_out, 32'd1000);

        // Random backpressure
        n_acc = 0;
        n_out = 0;
        cyc = 0;
        while ((n_acc < 300 || exp_q.size() > 0) && cyc < 3000) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.in_valid  = (n_acc < 300) && ($urandom_range(0, 3) != 0);
            bus.in_a      = W'($urandom_range(0, Q - 1));
            bus.in_b      = W'($urandom_range(0, Q - 1));
            bus.in_tag    = 8'(n_acc);
            #1;
            chk("bp_in_ready", {31'd0, bus.in_ready}, {31'd0, bus.out_ready | ~bus.out_valid});
            sb_cycle();
            cyc++;
        end
        chk("bp_accepted", n_acc, 32'd300);
        chk("bp_delivered", n_out, 32'd300);
        chk("bp_drained", exp_q.size(), 32'd0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();

        // Out-of-range operand, then three good pairs in flight
        chk("range_pre", {31'd0, bus.range_err}, 32'd0);
        bus.in_a     = W'(12289);
        bus.in_b     = W'(1);
        bus.in_tag   = 8'h55;
        bus.in_valid = 1'b1;
        step();
        chk("range_set", {31'd0, bus.range_err}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            bus.in_a   = W'(7 + 2 * i);
            bus.in_b   = W'(8 + 2 * i);
            bus.in_tag = 8'(i);
            step();
            chk("range_sticky", {31'd0, bus.range_err}, 32'd1);
        end
        bus.in_valid = 1'b0;
        chk("range_bad_pair_emitted", {31'd0, bus.out_valid}, 32'd1);
        chk("range_bad_pair_tag", {24'd0, bus.out_tag}, 32'h55);

        // Asynchronous reset between clock edges
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_range_err", {31'd0, bus.range_err}, 32'd0);
        chk("midrst_out_c", {18'd0, bus.out_c}, 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("post_rst_quiet", {31'd0, bus.out_valid}, 32'd0);
        end
        corner(100, 200, 8'h77, 7711);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
